debug_trap_ctrl: RTL and testbench

Collects per-breakpoint data-access hits from the read and write debug stages of the pipeline. It masks them with the DR7 local/global enables and accumulates them over the lifetime of one instruction. When that instruction retires, it raises a trap-class #DB request toward the exception unit, with the DR6 B0–B3 bits to set. It sits directly downstream of the read debug-match stage and consumes its held `rd_debug_read` vector.

---
 rtl/debug_trap_ctrl_if.sv | 27 ++
 rtl/debug_trap_ctrl.sv | 101 ++++++++++
 tb/tb_debug_trap_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_trap_ctrl_if.sv
// Signal bundle between the pipeline/exception unit and debug_trap_ctrl.
// The master side drives the pipeline status; the slave (the controller) returns the #DB request.
interface debug_trap_ctrl_if;
  logic [31:0] dr7;
  logic        rd_ready;
  logic [3:0]  rd_debug_read;
  logic        wr_done;
  logic [3:0]  wr_debug_write;
  logic        instr_done;
  logic        pipeline_flush;
  logic        exc_ack;
  logic        dbg_trap_req;
  logic [3:0]  dbg_b_hits;
  logic [7:0]  dbg_trap_count;

  modport master (
    output dr7, rd_ready, rd_debug_read, wr_done, wr_debug_write,
           instr_done, pipeline_flush, exc_ack,
    input  dbg_trap_req, dbg_b_hits, dbg_trap_count
  );

  modport slave (
    input  dr7, rd_ready, rd_debug_read, wr_done, wr_debug_write,
           instr_done, pipeline_flush, exc_ack,
    output dbg_trap_req, dbg_b_hits, dbg_trap_count
  );
endinterface

// File: rtl/debug_trap_ctrl.sv
// Accumulates DR7-enabled data breakpoint hits across one instruction and raises a
// trap-class #DB request with the DR6 B3..B0 bits once that instruction retires.
module debug_trap_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  debug_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REQ
  } state_t;

  state_t      state, state_next;
  logic [3:0]  en;
  logic [3:0]  hit;
  logic [3:0]  acc, acc_next;
  logic        trap_req, trap_req_next;
  logic [3:0]  b_hits, b_hits_next;
  logic [7:0]  count, count_next;
  logic        unused_dr7;

  // Only the L/G enable pairs matter here; the rest of DR7 belongs to other units.
  assign unused_dr7 = ^bus.dr7[31:8];

  always_comb begin
    en  = {bus.dr7[7] | bus.dr7[6], bus.dr7[5] | bus.dr7[4],
           bus.dr7[3] | bus.dr7[2], bus.dr7[1] | bus.dr7[0]};
    hit = ((bus.rd_ready ? bus.rd_debug_read  : 4'b0000) |
           (bus.wr_done  ? bus.wr_debug_write : 4'b0000)) & en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      trap_req <= 1'b0;
      b_hits   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      trap_req <= trap_req_next;
      b_hits   <= b_hits_next;
      count    <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;

    case (state)
      IDLE: begin
        // A flush wins over everything, so a hit sampled alongside it is dropped.
        if (!bus.pipeline_flush && (hit != 4'b0000)) begin
          acc_next   = hit;
          state_next = bus.instr_done ? REQ : ACCUM;
        end
      end

      ACCUM: begin
        if (bus.pipeline_flush) begin
          acc_next   = '0;
          state_next = IDLE;
        end else begin
          acc_next = acc | hit;
          if (bus.instr_done) begin
            state_next = REQ;
          end
        end
      end

      REQ: begin
        // The trap belongs to an already-retired instruction: only the ack moves us on.
        if (bus.exc_ack) begin
          acc_next   = '0;
          count_next = count + 8'd1;
          state_next = IDLE;
        end
      end

      default: begin
        acc_next   = '0;
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so the request appears the
    // cycle after retire and drops the cycle after the ack.
    trap_req_next = (state_next == REQ);
    b_hits_next   = trap_req_next ? acc_next : 4'b0000;
  end

  assign bus.dbg_trap_req   = trap_req;
  assign bus.dbg_b_hits     = b_hits;
  assign bus.dbg_trap_count = count;

endmodule

// File: tb/tb_debug_trap_ctrl.sv
// Scoreboard bench for debug_trap_ctrl: a set-based reference model queues expected
// traps and acks as stimulus is issued; a negedge monitor checks them as they appear.
module tb_debug_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_trap_ctrl_if bus ();

  debug_trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  hits;
    int unsigned cyc;
  } trap_exp_t;

  typedef struct {
    logic [7:0]  cnt;
    int unsigned cyc;
  } ack_exp_t;

  trap_exp_t   trapq[$];
  ack_exp_t    ackq[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  // Reference model: a pending hit set for the current instruction and a trap flag.
  logic [3:0]  m_pend;
  logic        m_trap;
  logic [7:0]  m_count;
  logic [31:0] cur_dr7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_trap  = 1'b0;
    m_count = '0;
    trapq.delete();
    ackq.delete();
  endtask

  // Drive one cycle of inputs (called at posedge+1), update the model, advance a cycle.
  task automatic step(input logic rr, input logic [3:0] rdv, input logic wd,
                      input logic [3:0] wrv, input logic id, input logic fl,
                      input logic ack);
    logic [3:0] en;
    logic [3:0] hit;
    bus.dr7            = cur_dr7;
    bus.rd_ready       = rr;
    bus.rd_debug_read  = rdv;
    bus.wr_done        = wd;
    bus.wr_debug_write = wrv;
    bus.instr_done     = id;
    bus.pipeline_flush = fl;
    bus.exc_ack        = ack;
    for (int i = 0; i < 4; i++) en[i] = cur_dr7[2*i] | cur_dr7[2*i+1];
    hit = ((rr ? rdv : 4'b0000) | (wd ? wrv : 4'b0000)) & en;
    if (m_trap) begin
      if (ack) begin
        m_trap  = 1'b0;
        m_count = m_count + 8'd1;
        ackq.push_back('{cnt: m_count, cyc: cyc + 1});
      end
    end else if (fl) begin
      m_pend = '0;
    end else begin
      m_pend = m_pend | hit;
      if (id && (m_pend != 4'b0000)) begin
        trapq.push_back('{hits: m_pend, cyc: cyc + 1});
        m_trap = 1'b1;
        m_pend = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops an expected trap on each request rise and an expected ack on each fall.
  logic       prev_req = 1'b0;
  logic [3:0] cur_hits = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.dbg_trap_req && !prev_req) begin
        if (trapq.size() == 0) begin
          chk("unexpected_trap", 32'(bus.dbg_b_hits), 32'hffff_ffff);
        end else begin
          trap_exp_t t;
          t = trapq.pop_front();
          chk("trap_hits", 32'(bus.dbg_b_hits), 32'(t.hits));
          chk("trap_latency", cyc, t.cyc);
          cur_hits = t.hits;
        end
      end else if (bus.dbg_trap_req) begin
        chk("hits_stable", 32'(bus.dbg_b_hits), 32'(cur_hits));
      end
      if (!bus.dbg_trap_req) begin
        chk("hits_zero_idle", 32'(bus.dbg_b_hits), 32'h0);
        if (prev_req) begin
          if (ackq.size() == 0) begin
            chk("unexpected_drop", cyc, 32'hffff_ffff);
          end else begin
            ack_exp_t a;
            a = ackq.pop_front();
            chk("trap_count", 32'(bus.dbg_trap_count), 32'(a.cnt));
            chk("ack_latency", cyc, a.cyc);
          end
        end
      end
      prev_req = bus.dbg_trap_req;
    end
  end

  initial begin
    rst_n   = 1'b0;
    cur_dr7 = '0;
    model_reset();
    bus.dr7 = '0;
    bus.rd_ready = 1'b0; bus.rd_debug_read = '0;
    bus.wr_done = 1'b0;  bus.wr_debug_write = '0;
    bus.instr_done = 1'b0; bus.pipeline_flush = 1'b0; bus.exc_ack = 1'b0;
    #1;
    chk("reset_req", 32'(bus.dbg_trap_req), 32'h0);
    chk("reset_hits", 32'(bus.dbg_b_hits), 32'h0);
    chk("reset_count", 32'(bus.dbg_trap_count), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read hit, retire two cycles later, ack after three request cycles.
    cur_dr7 = 32'h0000_0001;
    idle();
    step(1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(); idle();
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("single_count", 32'(bus.dbg_trap_count), 32'h1);

    // Masking and merge: only B1/B3 enabled.
    cur_dr7 = 32'h0000_0044;
    step(1'b1, 4'b1111, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle();

    // Same-cycle hit and retire from IDLE.
    cur_dr7 = 32'h0000_0010;
    step(1'b1, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle();

    // Flush cancels accumulated hit; a later retire alone raises nothing.
    cur_dr7 = 32'h0000_0001;
    step(1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("flush_no_trap", 32'(bus.dbg_trap_req), 32'h0);

    // REQ immunity: hit, flush and retire during the request are ignored.
    cur_dr7 = 32'h0000_00ff;
    step(1'b1, 4'b0001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    idle();
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    chk("immunity_no_second", 32'(bus.dbg_trap_req), 32'h0);

    // Asynchronous reset while a request is pending.
    step(1'b1, 4'b0010, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("req_before_reset", 32'(bus.dbg_trap_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(bus.dbg_trap_req), 32'h0);
    chk("async_hits", 32'(bus.dbg_b_hits), 32'h0);
    chk("async_count", 32'(bus.dbg_trap_count), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 256 acked traps wrap the counter back to zero.
    cur_dr7 = 32'h0000_0002;
    for (int n = 0; n < 256; n++) begin
      step(1'b1, 4'b0001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    end
    idle();
    chk("count_wrap", 32'(bus.dbg_trap_count), 32'h0);

    // Randomised traffic, including DR7 changes while hits are pending.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0) cur_dr7 = $urandom;
      step($urandom_range(0, 9) < 3, 4'($urandom), $urandom_range(0, 9) < 3, 4'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) < 4);
    end

    // Drain any outstanding request.
    repeat (4) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    chk("traps_left", trapq.size(), 32'h0);
    chk("acks_left", ackq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
